// File: rtl/riscv_pkg.sv
// Shared RISC-V decode definitions: opcodes, immediate formats and the decoded
// bundle carried from the decode stage to execute.
package riscv_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   typedef enum logic [2:0] {
      IMM_NONE,
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_U,
      IMM_J
   } imm_type_e;

   // imm is kept at 32 bits; the stage sign-extends it to XLEN on output.
   typedef struct packed {
      logic [4:0]  rs1_addr;
      logic [4:0]  rs2_addr;
      logic [4:0]  rd_addr;
      logic [6:0]  opcode;
      logic [2:0]  funct3;
      logic [6:0]  funct7;
      logic [31:0] imm;
      logic        is_imm;
      logic        rd_we;
      logic        illegal;
   } dec_bundle_t;

   function automatic logic [31:0] gen_imm(input logic [31:0] instr, input imm_type_e kind);
      logic [31:0] imm;
      imm = '0;
      case (kind)
         IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
         IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         IMM_U:   imm = {instr[31:12], 12'b0};
         IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default: imm = '0;
      endcase
      return imm;
   endfunction

endpackage

// File: rtl/instr_field_decode.sv
// Combinational field extraction: register/control fields, immediate, register
// usage flags and the illegal-instruction check.
module instr_field_decode
   import riscv_pkg::*;
#(
   parameter int NREG = 32
) (
   input  logic [31:0] instr,
   output dec_bundle_t dec,
   output logic        use_rs1,
   output logic        use_rs2
);

   imm_type_e   kind;
   logic        known;
   logic        has_rd;
   logic        has_rs1;
   logic        has_rs2;
   logic        has_f3;
   logic        has_f7;
   logic        bad_reg;
   logic        illegal;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [31:0] imm32;

   assign rd  = instr[11:7];
   assign rs1 = instr[19:15];
   assign rs2 = instr[24:20];

   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves
      // one unassigned, which would otherwise infer a latch.
      kind    = IMM_NONE;
      known   = 1'b1;
      has_rd  = 1'b0;
      has_rs1 = 1'b0;
      has_rs2 = 1'b0;
      has_f3  = 1'b0;
      has_f7  = 1'b0;
      case (instr[6:0])
         OP_R: begin
            has_rd = 1'b1; has_rs1 = 1'b1; has_rs2 = 1'b1; has_f3 = 1'b1; has_f7 = 1'b1;
         end
         OP_IMM, OP_LOAD, OP_JALR: begin
            kind = IMM_I; has_rd = 1'b1; has_rs1 = 1'b1; has_f3 = 1'b1;
         end
         OP_STORE: begin
            kind = IMM_S; has_rs1 = 1'b1; has_rs2 = 1'b1; has_f3 = 1'b1;
         end
         OP_BRANCH: begin
            kind = IMM_B; has_rs1 = 1'b1; has_rs2 = 1'b1; has_f3 = 1'b1;
         end
         OP_LUI, OP_AUIPC: begin
            kind = IMM_U; has_rd = 1'b1;
         end
         OP_JAL: begin
            kind = IMM_J; has_rd = 1'b1;
         end
         default: known = 1'b0;
      endcase

      // Only fields the format actually uses can make the instruction illegal.
      bad_reg = (has_rd  && ({1'b0, rd}  >= 6'(NREG))) ||
                (has_rs1 && ({1'b0, rs1} >= 6'(NREG))) ||
                (has_rs2 && ({1'b0, rs2} >= 6'(NREG)));
      illegal = !known || bad_reg;
      imm32   = gen_imm(instr, kind);

      dec         = '0;
      dec.opcode  = instr[6:0];
      dec.illegal = illegal;
      use_rs1     = 1'b0;
      use_rs2     = 1'b0;
      if (!illegal) begin
         dec.rs1_addr = has_rs1 ? rs1 : 5'd0;
         dec.rs2_addr = has_rs2 ? rs2 : 5'd0;
         dec.rd_addr  = has_rd  ? rd  : 5'd0;
         dec.funct3   = has_f3  ? instr[14:12] : 3'd0;
         dec.funct7   = has_f7  ? instr[31:25] : 7'd0;
         dec.imm      = imm32;
         dec.is_imm   = kind inside {IMM_I, IMM_S, IMM_B, IMM_J};
         dec.rd_we    = has_rd && (rd != 5'd0);
         use_rs1      = has_rs1;
         use_rs2      = has_rs2;
      end
   end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage between fetch and execute: valid/ready handshake,
// decoded output register and a busy-bit scoreboard for RAW hazards.
module decode_stage
   import riscv_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int NREG  = 32,
   parameter bit SB_EN = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [4:0]      out_rs1_addr,
   output logic [4:0]      out_rs2_addr,
   output logic [4:0]      out_rd_addr,
   output logic [6:0]      out_opcode,
   output logic [2:0]      out_funct3,
   output logic [6:0]      out_funct7,
   output logic [XLEN-1:0] out_imm,
   output logic            out_is_imm,
   output logic            out_rd_we,
   output logic            out_illegal,
   input  logic            wb_valid,
   input  logic [4:0]      wb_rd_addr,
   input  logic            flush
);

   dec_bundle_t     dec;
   dec_bundle_t     out_q;
   logic [XLEN-1:0] pc_q;
   logic            out_valid_q;
   logic            use_rs1;
   logic            use_rs2;
   logic [NREG-1:0] busy;
   logic [NREG-1:0] busy_nxt;
   logic [31:0]     busy_ext;
   logic            pend_rs1;
   logic            pend_rs2;
   logic            hazard;
   logic            acc;

   instr_field_decode #(.NREG(NREG)) u_field_decode (
      .instr   (in_instr),
      .dec     (dec),
      .use_rs1 (use_rs1),
      .use_rs2 (use_rs2)
   );

   always_comb begin
      // Widened view so a 5-bit index never reads past the NREG busy bits;
      // indices >= NREG only reach here from illegal words, whose use flags are 0.
      busy_ext = 32'(busy);
      pend_rs1 = busy_ext[dec.rs1_addr] && !(wb_valid && wb_rd_addr == dec.rs1_addr);
      pend_rs2 = busy_ext[dec.rs2_addr] && !(wb_valid && wb_rd_addr == dec.rs2_addr);
      hazard   = SB_EN && ((use_rs1 && pend_rs1) || (use_rs2 && pend_rs2));
      in_ready = !flush && (!out_valid_q || out_ready) && !hazard;
      acc      = in_valid && in_ready;
      // Set after clear so a new writer of the same register wins.
      for (int i = 0; i < NREG; i++) begin
         busy_nxt[i] = (busy[i] && !(wb_valid && wb_rd_addr == 5'(i))) ||
                       (acc && dec.rd_we && dec.rd_addr == 5'(i));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: state registers use non-blocking assignments so every flop samples
      // the pre-edge values regardless of statement order.
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_q       <= '0;
         pc_q        <= '0;
         busy        <= '0;
      end else if (flush) begin
         out_valid_q <= 1'b0;
         busy        <= '0;
      end else begin
         if (acc) begin
            out_valid_q <= 1'b1;
            out_q       <= dec;
            pc_q        <= in_pc;
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end
         busy <= busy_nxt;
      end
   end

   assign out_valid    = out_valid_q;
   assign out_pc       = pc_q;
   assign out_rs1_addr = out_q.rs1_addr;
   assign out_rs2_addr = out_q.rs2_addr;
   assign out_rd_addr  = out_q.rd_addr;
   assign out_opcode   = out_q.opcode;
   assign out_funct3   = out_q.funct3;
   assign out_funct7   = out_q.funct7;
   assign out_imm      = XLEN'($signed(out_q.imm));
   assign out_is_imm   = out_q.is_imm;
   assign out_rd_we    = out_q.rd_we;
   assign out_illegal  = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: expected bundles are queued on accept and
// compared when execute consumes them; a second instance runs with NREG = 16.
module tb_decode_stage;

   typedef struct {
      logic [31:0] pc;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] imm;
      logic        is_imm;
      logic        rd_we;
      logic        ill;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_instr, in_pc, out_pc, out_imm;
   logic [4:0]  out_rs1_addr, out_rs2_addr, out_rd_addr, wb_rd_addr;
   logic [6:0]  out_opcode, out_funct7;
   logic [2:0]  out_funct3;
   logic        out_is_imm, out_rd_we, out_illegal, wb_valid, flush;

   logic        e_in_valid, e_in_ready, e_out_valid;
   logic [31:0] e_in_instr, e_out_pc, e_out_imm;
   logic [4:0]  e_out_rs1_addr, e_out_rs2_addr, e_out_rd_addr;
   logic [6:0]  e_out_opcode, e_out_funct7;
   logic [2:0]  e_out_funct3;
   logic        e_out_is_imm, e_out_rd_we, e_out_illegal;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   n_acc   = 0;
   exp_t cur_exp;
   exp_t sb[$];

   always #5 clk = ~clk;

   decode_stage dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_rs1_addr(out_rs1_addr), .out_rs2_addr(out_rs2_addr), .out_rd_addr(out_rd_addr),
      .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
      .out_imm(out_imm), .out_is_imm(out_is_imm), .out_rd_we(out_rd_we),
      .out_illegal(out_illegal), .wb_valid(wb_valid), .wb_rd_addr(wb_rd_addr), .flush(flush)
   );

   decode_stage #(.NREG(16)) dut_e (
      .clk(clk), .rst_n(rst_n),
      .in_valid(e_in_valid), .in_ready(e_in_ready), .in_instr(e_in_instr), .in_pc(32'h300),
      .out_valid(e_out_valid), .out_ready(1'b1), .out_pc(e_out_pc),
      .out_rs1_addr(e_out_rs1_addr), .out_rs2_addr(e_out_rs2_addr), .out_rd_addr(e_out_rd_addr),
      .out_opcode(e_out_opcode), .out_funct3(e_out_funct3), .out_funct7(e_out_funct7),
      .out_imm(e_out_imm), .out_is_imm(e_out_is_imm), .out_rd_we(e_out_rd_we),
      .out_illegal(e_out_illegal), .wb_valid(1'b0), .wb_rd_addr(5'd0), .flush(1'b0)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t mk(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic [6:0] op, input logic [2:0] f3,
                               input logic [6:0] f7, input logic [31:0] imm, input logic is_imm,
                               input logic rd_we, input logic ill);
      exp_t e;
      e.pc = pc; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.op = op; e.f3 = f3; e.f7 = f7;
      e.imm = imm; e.is_imm = is_imm; e.rd_we = rd_we; e.ill = ill;
      return e;
   endfunction

   task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input exp_t e);
      in_valid = 1'b1;
      in_instr = instr;
      in_pc    = pc;
      cur_exp  = e;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: inputs change just after posedge, so negedge sees what the next edge will.
   always @(negedge clk) begin
      if (rst_n) begin
         if (flush) begin
            if (out_valid && sb.size() > 0) void'(sb.pop_front());
         end else if (out_valid && out_ready) begin
            check("out_has_expect", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
               exp_t e;
               e = sb.pop_front();
               check("out_pc", 64'(out_pc), 64'(e.pc));
               check("out_rs1", 64'(out_rs1_addr), 64'(e.rs1));
               check("out_rs2", 64'(out_rs2_addr), 64'(e.rs2));
               check("out_rd", 64'(out_rd_addr), 64'(e.rd));
               check("out_opcode", 64'(out_opcode), 64'(e.op));
               check("out_funct3", 64'(out_funct3), 64'(e.f3));
               check("out_funct7", 64'(out_funct7), 64'(e.f7));
               check("out_imm", 64'(out_imm), 64'(e.imm));
               check("out_is_imm", 64'(out_is_imm), 64'(e.is_imm));
               check("out_rd_we", 64'(out_rd_we), 64'(e.rd_we));
               check("out_illegal", 64'(out_illegal), 64'(e.ill));
            end
         end
         if (in_valid && in_ready) begin
            sb.push_back(cur_exp);
            n_acc++;
         end
      end
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b1;
      wb_valid = 1'b0; wb_rd_addr = '0; flush = 1'b0; e_in_valid = 1'b0; e_in_instr = '0;
      cur_exp = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #2;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_pc", 64'(out_pc), 64'd0);
      check("rst_out_imm", 64'(out_imm), 64'd0);
      check("rst_out_fields", 64'({out_rd_addr, out_opcode, out_illegal, out_rd_we}), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_busy", 64'(dut.busy), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // addi x1,x0,5
      drive(32'h00500093, 32'h100, mk(32'h100, 0, 0, 1, 7'h13, 0, 0, 32'd5, 1, 1, 0));
      step();
      check("single_out_valid", 64'(out_valid), 64'd1);
      check("single_busy1", 64'(dut.busy[1]), 64'd1);

      // add x2,x1,x1 stalls on x1 until writeback, then goes in that same cycle
      drive(32'h00108133, 32'h104, mk(32'h104, 1, 1, 2, 7'h33, 0, 0, 32'd0, 0, 1, 0));
      #1 check("raw_stall_0", 64'(in_ready), 64'd0);
      step();
      check("raw_stall_1", 64'(in_ready), 64'd0);
      check("raw_bubble", 64'(out_valid), 64'd0);
      wb_valid = 1'b1; wb_rd_addr = 5'd1;
      #1 check("raw_wb_release", 64'(in_ready), 64'd1);
      step();
      wb_valid = 1'b0; in_valid = 1'b0;
      check("raw_busy1_clear", 64'(dut.busy[1]), 64'd0);
      check("raw_busy2_set", 64'(dut.busy[2]), 64'd1);

      // sw x2,-4(x1), x2 retired the same cycle
      drive(32'hFE20AE23, 32'h108, mk(32'h108, 1, 2, 0, 7'h23, 2, 0, 32'hFFFFFFFC, 1, 0, 0));
      wb_valid = 1'b1; wb_rd_addr = 5'd2;
      #1 check("store_ready", 64'(in_ready), 64'd1);
      step();
      wb_valid = 1'b0;

      // lui x5,0x12345 offered under backpressure
      drive(32'h123452B7, 32'h10C, mk(32'h10C, 0, 0, 5, 7'h37, 0, 0, 32'h12345000, 0, 1, 0));
      out_ready = 1'b0;
      #1 check("bp_in_ready", 64'(in_ready), 64'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("bp_valid", 64'(out_valid), 64'd1);
         check("bp_hold", 64'({out_pc, out_imm}), {32'h108, 32'hFFFFFFFC});
         check("bp_hold_regs", 64'({out_rs1_addr, out_rs2_addr, out_funct3}), 64'({5'd1, 5'd2, 3'd2}));
         check("bp_in_ready_hold", 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      #1 check("bp_release_ready", 64'(in_ready), 64'd1);
      step();
      check("bp_no_bubble", 64'({out_valid, out_rd_addr}), 64'({1'b1, 5'd5}));

      // jal x3,-4 and bne x1,x2,+8 back to back
      drive(32'hFFDFF1EF, 32'h110, mk(32'h110, 0, 0, 3, 7'h6F, 0, 0, 32'hFFFFFFFC, 1, 1, 0));
      #1 check("tput_jal_ready", 64'(in_ready), 64'd1);
      step();
      drive(32'h00209463, 32'h114, mk(32'h114, 1, 2, 0, 7'h63, 1, 0, 32'd8, 1, 0, 0));
      #1 check("tput_bne_ready", 64'(in_ready), 64'd1);
      step();
      in_valid = 1'b0;
      step();

      // flush with x1 busy, output held and a new instruction offered
      drive(32'h00500093, 32'h200, mk(32'h200, 0, 0, 1, 7'h13, 0, 0, 32'd5, 1, 1, 0));
      out_ready = 1'b0;
      step();
      check("fl_pre_valid", 64'(out_valid), 64'd1);
      check("fl_pre_busy1", 64'(dut.busy[1]), 64'd1);
      drive(32'h00100313, 32'h204, mk(32'h204, 0, 0, 6, 7'h13, 0, 0, 32'd1, 1, 1, 0));
      flush = 1'b1;
      #1 check("fl_in_ready", 64'(in_ready), 64'd0);
      step();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      check("fl_out_valid", 64'(out_valid), 64'd0);
      check("fl_busy", 64'(dut.busy), 64'd0);
      check("fl_nothing_taken", 64'(sb.size()), 64'd0);

      // x17: legal with 32 registers, illegal on the RV32E instance
      drive(32'h00100893, 32'h208, mk(32'h208, 0, 0, 17, 7'h13, 0, 0, 32'd1, 1, 1, 0));
      e_in_valid = 1'b1; e_in_instr = 32'h00100893;
      step();
      in_valid = 1'b0; e_in_valid = 1'b0;
      check("e_valid", 64'(e_out_valid), 64'd1);
      check("e_illegal", 64'(e_out_illegal), 64'd1);
      check("e_rd_we", 64'(e_out_rd_we), 64'd0);
      check("e_fields", 64'({e_out_rd_addr, e_out_imm, e_out_is_imm}), 64'd0);
      check("e_opcode", 64'(e_out_opcode), 64'h13);
      check("e_busy", 64'(dut_e.busy), 64'd0);
      check("x17_busy", 64'(dut.busy), 64'h0002_0000);

      // unknown opcode 0x7F with every field bit set
      drive(32'hFFFFFFFF, 32'h20C, mk(32'h20C, 0, 0, 0, 7'h7F, 0, 0, 32'd0, 0, 0, 1));
      #1 check("ill_ready", 64'(in_ready), 64'd1);
      step();
      in_valid = 1'b0;
      check("ill_busy_untouched", 64'(dut.busy), 64'h0002_0000);

      repeat (3) step();
      check("drain_empty", 64'(sb.size()), 64'd0);
      check("accept_count", 64'(n_acc), 64'd9);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised successor to the combinational instruction decoder, placed between fetch and execute. Each cycle it accepts one instruction over a valid/ready handshake and decodes register fields, control fields and the sign-extended immediate into a single output register. A register scoreboard stalls instructions with read-after-write hazards. Supported instruction groups: R, I (ALU/load/JALR), S, B, U, J.

## Interface
- `XLEN`, default 32: width of the PC and the immediate.
- `NREG`, default 32: architectural register count, 32 or 16 (RV32E). Register indices ≥ `NREG` are illegal.
- `SB_EN`, default 1: 1 enables the scoreboard; 0 ties the hazard signal low.
- `clk` in 1: clock, rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: fetch offers an instruction.
- `in_ready` out 1: stage accepts this cycle.
- `in_instr` in 32: instruction word.
- `in_pc` in XLEN: instruction PC.
- `out_valid` out 1: decoded bundle valid.
- `out_ready` in 1: execute consumes the bundle.
- `out_pc` out XLEN: registered PC.
- `out_rs1_addr`, `out_rs2_addr`, `out_rd_addr` out 5: register indices; zero when the field is unused.
- `out_opcode` out 7, `out_funct3` out 3, `out_funct7` out 7: control fields; funct fields are zero when unused.
- `out_imm` out XLEN: sign-extended immediate.
- `out_is_imm` out 1: instruction is I, S, B or J type.
- `out_rd_we` out 1: instruction writes rd, and rd ≠ 0.
- `out_illegal` out 1: unknown opcode, or a register index ≥ `NREG`.
- `wb_valid` in 1: writeback retires a register write.
- `wb_rd_addr` in 5: register being retired.
- `flush` in 1: squash the stage.

## Operation
- **Accept:** `acc = in_valid & in_ready`.
- **Ready:** `in_ready = !flush & (!out_valid | out_ready) & !hazard`.
- **Hazard:** `hazard = (use_rs1 & pend(rs1)) | (use_rs2 & pend(rs2))`.
  - `pend(r) = busy[r] & !(wb_valid & wb_rd_addr == r)`, so a writeback in the same cycle unblocks the read.
  - Register x0 is never busy.
- **Register usage:**
  - R, B, S: use rs1 and rs2.
  - I: uses rs1 only.
  - U, J: use neither.
  - Only fields that are used are checked against `NREG`.
- **Immediates:**
  - I: `instr[31:20]`.
  - S: `{instr[31:25], instr[11:7]}`.
  - B: `{instr[31], instr[7], instr[30:25], instr[11:8], 0}`.
  - U: `{instr[31:12], 12'b0}`.
  - J: `{instr[31], instr[19:12], instr[20], instr[30:21], 0}`.
  - All immediates are sign-extended from `instr[31]` to `XLEN`. R type gives 0.
- **Illegal instruction:**
  - `out_illegal` = 1, `out_rd_we` = 0, `out_is_imm` = 0.
  - All address, funct and immediate outputs are 0; `out_opcode` still carries `instr[6:0]`.
  - The scoreboard is not touched.
- **Scoreboard:**
  - Holds `NREG` busy bits.
  - Set `busy[rd]` on `acc & rd_we`.
  - Clear `busy[wb_rd_addr]` on `wb_valid`.
  - If set and clear hit the same register in the same cycle, set wins.
- **Flush:**
  - Next edge: `out_valid` = 0 and all busy bits cleared.
  - Flush has priority over accept and writeback in the same cycle.
- **Backpressure:** while `out_valid & !out_ready`, all `out_*` outputs hold stable.

## Timing
- Latency: 1 cycle from accept to `out_valid`.
- Throughput: 1 instruction per cycle with no hazards and `out_ready` = 1.
- Accept while `out_ready` = 1 (full-throughput case): the register reloads on that edge, with no bubble.
- Reset (asynchronous): `out_valid` and every `out_*` output 0; busy bits 0.
  - `in_ready` follows from this state: 1 when `flush` = 0.
- Reset asserted mid-operation: the in-flight bundle is dropped with no handshake.
- `in_ready` is combinational from `in_instr`, `out_ready`, `wb_*` and `flush`.
  - Fetch must not make `in_valid` depend on `in_ready`.

## Structure
- Shared package `riscv_pkg`:
  - Opcode constants (`OP_R`, `OP_IMM`, `OP_LOAD`, `OP_JALR`, `OP_BRANCH`, `OP_STORE`, `OP_LUI`, `OP_AUIPC`, `OP_JAL`).
  - Enum `imm_type_e` (I/S/B/U/J/NONE).
  - Struct `dec_bundle_t` holding the output fields.
- Sub-module `instr_field_decode`: purely combinational; performs field extraction, immediate generation, use/we flags and the illegal check.
- Top level `decode_stage` holds the pipeline register, handshake logic and scoreboard.

## Test plan
- **Single accept:** `in_instr` = 0x00500093 (addi x1,x0,5) with `in_valid` = 1 → next cycle:
  - `out_valid` = 1, `rd` = 1, `rs1` = 0, `imm` = 5.
  - `out_is_imm` = 1, `out_rd_we` = 1, `busy[1]` = 1.
- **RAW stall:** then 0x00108133 (add x2,x1,x1) → `in_ready` = 0 until `wb_valid` = 1 with `wb_rd_addr` = 1.
  - Accepted in that same cycle; `out_rs1_addr` = `out_rs2_addr` = 1, `out_rd_addr` = 2.
- **Store immediate:** 0xFE20AE23 (sw x2,-4(x1)) → `imm` = 0xFFFFFFFC, `rs1` = 1, `rs2` = 2, `funct3` = 2, `rd_we` = 0.
- **Backpressure:** `out_ready` = 0 for 3 cycles → outputs stable; `in_ready` = 0. Release → next instruction follows without a bubble.
- **Flush:** flush while `busy[1]` = 1, `out_valid` = 1 and `in_valid` = 1 → `out_valid` = 0, busy all 0, nothing accepted that cycle.
- **RV32E:** `NREG` = 16, 0x00100893 (addi x17,x0,1) → `out_illegal` = 1, `rd_we` = 0, no busy bit set.
- **Unknown opcode:** opcode 0x7F → `out_illegal` = 1, fields 0.
